// File: rtl/gouram_trace_pkg.sv
// Shared trace types for the stage trackers, the arbiter and the packetiser.
//   trace_format : record carried from the trackers to the sink
//   slot_entry_t : one buffered entry {record, stage-end cycle count}
//   arb_state_e  : output register state of trace_arbiter
package gouram_trace_pkg;

   localparam int ARB_MAX_REQ = 8;
   localparam int OVF_CNT_W   = 16;

   typedef logic [31:0] trace_format;

   typedef struct packed {
      trace_format data;
      logic [31:0] end_cyc;
   } slot_entry_t;

   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_HOLD = 1'b1
   } arb_state_e;

endpackage

// File: rtl/trace_arbiter_if.sv
// Tracker-to-sink trace bus.
//   req_valid/req_data/req_end : per-requester one-cycle record pulses
//   out_valid/out_ready        : valid/ready handshake toward the sink
//   out_data/out_src/out_end   : granted record, its source index and end count
// Modports: master = trackers + sink side, slave = trace_arbiter.
interface trace_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import gouram_trace_pkg::*;

   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req_valid;
   trace_format [NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0][31:0] req_end;
   logic                     out_valid;
   logic                     out_ready;
   trace_format              out_data;
   logic [SRC_W-1:0]         out_src;
   logic [31:0]              out_end;

   modport master (
      output req_valid, req_data, req_end, out_ready,
      input  out_valid, out_data, out_src, out_end
   );

   modport slave (
      input  req_valid, req_data, req_end, out_ready,
      output out_valid, out_data, out_src, out_end
   );

endinterface

// File: rtl/trace_slot_fifo.sv
// Per-requester slot FIFO of SLOT_DEPTH entries.
//   push/wdata : write request; taken when not full or when popped this cycle
//   pop        : remove the oldest entry (ignored when empty)
//   full/empty : occupancy flags
//   rdata      : oldest entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_slot_fifo
   import gouram_trace_pkg::*;
#(
   parameter int SLOT_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  slot_entry_t wdata,
   output logic        full,
   output logic        empty,
   output slot_entry_t rdata
);

   localparam int AW = $clog2(SLOT_DEPTH);
   localparam int IW = (AW > 0) ? AW : 1;
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [IW-1:0] wr_idx, rd_idx;
   logic          wr_en, rd_en;
   slot_entry_t   mem_q [SLOT_DEPTH];
   slot_entry_t   mem_d [SLOT_DEPTH];

   if (AW > 0) begin : g_idx
      assign wr_idx = wr_q[IW-1:0];
      assign rd_idx = rd_q[IW-1:0];
   end else begin : g_single
      assign wr_idx = '0;
      assign rd_idx = '0;
   end

   assign empty = (wr_q == rd_q);
   assign full  = ((wr_q - rd_q) == (AW + 1)'(SLOT_DEPTH));
   assign rdata = mem_q[rd_idx];

   // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (wr_en) begin
         mem_d[wr_idx] = wdata;
         wr_d          = wr_q + PTR_ONE;
      end
      if (rd_en) begin
         rd_d = rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         mem_q <= '{default: '0};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin arbiter sharing one trace output between the stage trackers.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : per-requester record pulses in, valid/ready record out
//   clr_overflow   : clears all sticky overflow flags (and counters)
//   overflow       : sticky per-requester drop flag
//   ovf_count      : per-requester saturating drop counters
// Build option GOURAM_ARB_OVF_CNT_EN: when defined, ovf_count counts drops;
// when undefined, ovf_count is tied to zero.
module trace_arbiter
   import gouram_trace_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int SLOT_DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   trace_arbiter_if.slave                    bus,
   input  logic                              clr_overflow,
   output logic [NUM_REQ-1:0]                overflow,
   output logic [NUM_REQ-1:0][OVF_CNT_W-1:0] ovf_count
);

   localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]              fifo_full, fifo_empty, fifo_pop, drop;
   slot_entry_t [NUM_REQ-1:0]       fifo_wdata, fifo_rdata;

   arb_state_e                      state_q, state_d;
   logic [SRC_W-1:0]                ptr_q, ptr_d;
   logic [SRC_W-1:0]                win;
   logic [SRC_W:0]                  scan;
   logic                            any_pending, load;
   trace_format                     out_data_q, out_data_d;
   logic [SRC_W-1:0]                out_src_q, out_src_d;
   logic [31:0]                     out_end_q, out_end_d;
   logic [NUM_REQ-1:0]              overflow_q, overflow_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      assign fifo_wdata[g] = {bus.req_data[g], bus.req_end[g]};

      trace_slot_fifo #(.SLOT_DEPTH(SLOT_DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (bus.req_valid[g]),
         .pop   (fifo_pop[g]),
         .wdata (fifo_wdata[g]),
         .full  (fifo_full[g]),
         .empty (fifo_empty[g]),
         .rdata (fifo_rdata[g])
      );
   end

   // First non-empty FIFO scanning ptr, ptr+1, ... modulo NUM_REQ.
   always_comb begin
      any_pending = 1'b0;
      win         = '0;
      scan        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, ptr_q} + (SRC_W + 1)'(k);
         if (scan >= (SRC_W + 1)'(NUM_REQ)) begin
            scan = scan - (SRC_W + 1)'(NUM_REQ);
         end
         if (!any_pending && !fifo_empty[scan[SRC_W-1:0]]) begin
            any_pending = 1'b1;
            win         = scan[SRC_W-1:0];
         end
      end
   end

   assign load = any_pending && ((state_q == OUT_IDLE) || bus.out_ready);

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         fifo_pop[i] = load && (win == SRC_W'(i));
      end
   end

   assign drop       = bus.req_valid & fifo_full & ~fifo_pop;
   // A drop in the clearing cycle keeps its flag.
   assign overflow_d = (clr_overflow ? '0 : overflow_q) | drop;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      out_end_d  = out_end_q;
      if (load) begin
         state_d    = OUT_HOLD;
         out_data_d = fifo_rdata[win].data;
         out_src_d  = win;
         out_end_d  = fifo_rdata[win].end_cyc;
         ptr_d      = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + SRC_W'(1);
      end else if (state_q == OUT_HOLD && bus.out_ready) begin
         state_d = OUT_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OUT_IDLE;
         ptr_q      <= '0;
         out_data_q <= '0;
         out_src_q  <= '0;
         out_end_q  <= '0;
         overflow_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         out_end_q  <= out_end_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.out_valid = (state_q == OUT_HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_end   = out_end_q;
   assign overflow      = overflow_q;

`ifdef GOURAM_ARB_OVF_CNT_EN
   logic [NUM_REQ-1:0][OVF_CNT_W-1:0] cnt_q, cnt_d;

   // Clear first, then count, so a drop during a clear leaves the counter at 1.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = clr_overflow ? '0 : cnt_q[i];
         if (drop[i] && (cnt_d[i] != '1)) begin
            cnt_d[i] = cnt_d[i] + OVF_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ovf_count = cnt_q;
`else
   assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_trace_arbiter.sv
// Bench for trace_arbiter: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model of the arbiter's behaviour.
module tb_trace_arbiter;
   import gouram_trace_pkg::*;

   localparam int NREQ  = 4;
   localparam int DEPTH = 2;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      clr_overflow;
   logic [NREQ-1:0]           overflow;
   logic [NREQ-1:0][15:0]     ovf_count;

   trace_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   trace_arbiter #(.NUM_REQ(NREQ), .SLOT_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .clr_overflow (clr_overflow),
      .overflow     (overflow),
      .ovf_count    (ovf_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] d;
      logic [31:0] e;
   } rec_t;

   rec_t            mq [NREQ][$];
   bit              m_valid;
   rec_t            m_rec;
   int              m_src;
   int              m_ptr;
   bit [NREQ-1:0]   m_ovf;
   int              m_cnt [NREQ];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) begin
         mq[i].delete();
         m_cnt[i] = 0;
      end
      m_valid = 0;
      m_src   = 0;
      m_ptr   = 0;
      m_ovf   = '0;
   endtask

   // One clock edge of arbiter behaviour, from the inputs presented this cycle.
   task automatic model_step();
      bit            load;
      int            win;
      bit [NREQ-1:0] popped;
      int            sz [NREQ];
      load   = 0;
      win    = 0;
      popped = '0;
      for (int i = 0; i < NREQ; i++) sz[i] = mq[i].size();
      if (!m_valid || bus.out_ready) begin
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!load && sz[idx] > 0) begin
               load = 1;
               win  = idx;
            end
         end
      end
      if (load) begin
         m_rec       = mq[win].pop_front();
         m_src       = win;
         m_valid     = 1;
         m_ptr       = (win + 1) % NREQ;
         popped[win] = 1;
      end else if (m_valid && bus.out_ready) begin
         m_valid = 0;
      end
      if (clr_overflow) begin
         m_ovf = '0;
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i]) begin
            if (sz[i] < DEPTH || popped[i]) begin
               mq[i].push_back({bus.req_data[i], bus.req_end[i]});
            end else begin
               m_ovf[i] = 1;
               if (m_cnt[i] < 65535) m_cnt[i]++;
            end
         end
      end
   endtask

   function automatic logic [63:0] exp_cnt_word();
      logic [NREQ-1:0][15:0] w;
      for (int i = 0; i < NREQ; i++) begin
`ifdef GOURAM_ARB_OVF_CNT_EN
         w[i] = 16'(m_cnt[i]);
`else
         w[i] = 16'h0;
`endif
      end
      return 64'(w);
   endfunction

   task automatic check_all();
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
         check("out_data", 64'(bus.out_data), 64'(m_rec.d));
         check("out_src",  64'(bus.out_src),  64'(m_src));
         check("out_end",  64'(bus.out_end),  64'(m_rec.e));
      end
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("ovf_count", 64'(ovf_count), exp_cnt_word());
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [NREQ-1:0] rv, input logic rdy, input logic clr);
      bus.req_valid = rv;
      bus.out_ready = rdy;
      clr_overflow  = clr;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_data[i] = $urandom;
         bus.req_end[i]  = $urandom;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive('0, 1'b0, 1'b0);
      model_reset();
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data",  64'(bus.out_data),  64'd0);
      check("rst_out_src",   64'(bus.out_src),   64'd0);
      check("rst_out_end",   64'(bus.out_end),   64'd0);
      check("rst_overflow",  64'(overflow),      64'd0);
      check("rst_ovf_count", 64'(ovf_count),     64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [31:0] d0, d2a, d2b, d2c;
   int          pct;

   initial begin
      rst_n = 1'b0;
      drive('0, 1'b0, 1'b0);
      do_reset();

      // Single push: out_valid two edges after the pulse, for one cycle.
      drive('0, 1'b1, 1'b0);
      repeat (3) tick();
      drive(4'b0010, 1'b1, 1'b0);
      bus.req_data[1] = 32'hA5;
      tick();
      drive('0, 1'b1, 1'b0);
      check("single_n1_valid", 64'(bus.out_valid), 64'd0);
      tick();
      check("single_n2_valid", 64'(bus.out_valid), 64'd1);
      check("single_n2_src",   64'(bus.out_src),   64'd1);
      check("single_n2_data",  64'(bus.out_data),  64'hA5);
      tick();
      check("single_n3_valid", 64'(bus.out_valid), 64'd0);

      // Simultaneous pulses from ptr=0: grants 0,1,2,3 back to back.
      do_reset();
      drive('1, 1'b1, 1'b0);
      tick();
      drive('0, 1'b1, 1'b0);
      for (int g = 0; g < NREQ; g++) begin
         tick();
         check("simul_valid", 64'(bus.out_valid), 64'd1);
         check("simul_src",   64'(bus.out_src),   64'(g));
      end
      tick();
      check("simul_drain", 64'(bus.out_valid), 64'd0);

      // Backpressure: output holds requester 0 while requester 2 overflows.
      do_reset();
      drive(4'b0001, 1'b0, 1'b0);
      d0 = bus.req_data[0];
      tick();
      drive('0, 1'b0, 1'b0);
      tick();
      for (int r = 0; r < 3; r++) begin
         drive(4'b0100, 1'b0, 1'b0);
         if (r == 0) d2a = bus.req_data[2];
         if (r == 1) d2b = bus.req_data[2];
         tick();
         check("bp_hold_data", 64'(bus.out_data), 64'(d0));
         check("bp_hold_src",  64'(bus.out_src),  64'd0);
      end
      drive('0, 1'b0, 1'b0);
      repeat (5) tick();
      check("bp_ovf2", 64'(overflow[2]), 64'd1);
`ifdef GOURAM_ARB_OVF_CNT_EN
      check("bp_cnt2", 64'(ovf_count[2]), 64'd1);
`else
      check("bp_cnt2", 64'(ovf_count[2]), 64'd0);
`endif
      drive('0, 1'b0, 1'b1);
      tick();
      check("clr_ovf", 64'(overflow), 64'd0);

      // Full FIFO 2 pushed while it is granted: push accepted, order kept.
      drive(4'b0100, 1'b1, 1'b0);
      d2c = bus.req_data[2];
      tick();
      check("fullpop_ovf",  64'(overflow[2]), 64'd0);
      check("fullpop_src",  64'(bus.out_src), 64'd2);
      check("fullpop_d0",   64'(bus.out_data), 64'(d2a));
      drive('0, 1'b1, 1'b0);
      tick();
      check("fullpop_d1", 64'(bus.out_data), 64'(d2b));
      tick();
      check("fullpop_d2", 64'(bus.out_data), 64'(d2c));
      tick();
      check("fullpop_end", 64'(bus.out_valid), 64'd0);

      // Fairness: requesters 0 and 3 refilled every cycle alternate.
      do_reset();
      drive(4'b1001, 1'b1, 1'b0);
      tick();
      for (int j = 0; j < 8; j++) begin
         drive(4'b1001, 1'b1, 1'b0);
         tick();
         check("fair_src", 64'(bus.out_src), (j % 2 == 1) ? 64'd3 : 64'd0);
      end

      // Asynchronous reset in OUT_HOLD, away from any clock edge.
      check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
      #2;
      do_reset();
      drive('1, 1'b1, 1'b0);
      tick();
      drive('0, 1'b1, 1'b0);
      tick();
      check("post_rst_src", 64'(bus.out_src), 64'd0);

      // Randomized traffic with varying sink readiness.
      do_reset();
      for (int blk = 0; blk < 6; blk++) begin
         case (blk)
            0: pct = 90;
            1: pct = 30;
            2: pct = 60;
            3: pct = 100;
            4: pct = 10;
            default: pct = 70;
         endcase
         for (int c = 0; c < 100; c++) begin
            logic [NREQ-1:0] rv;
            for (int i = 0; i < NREQ; i++) rv[i] = ($urandom_range(99) < 35);
            drive(rv, ($urandom_range(99) < pct), ($urandom_range(99) < 4));
            tick();
         end
      end
      drive('0, 1'b1, 1'b0);
      repeat (12) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
